// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED mode sequencer.
// Holds the display-mode enum and small pure helpers used by the top level.
package led_seq_pkg;

   localparam int LED_W     = 6;
   localparam int SCAN_LAST = 5;
   localparam int DUTY_MAX  = 63;

   typedef enum logic [1:0] {
      MODE_BINARY  = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_GRAY    = 2'd3
   } mode_t;

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_BINARY:  next_mode = MODE_SCAN;
         MODE_SCAN:    next_mode = MODE_BREATHE;
         MODE_BREATHE: next_mode = MODE_GRAY;
         default:      next_mode = MODE_BINARY;
      endcase
   endfunction

   function automatic logic [LED_W-1:0] bin_to_gray(input logic [LED_W-1:0] b);
      bin_to_gray = b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, run-length debouncer and a
// one-cycle press pulse on each accepted rising level.
module key_debounce #(
   parameter int DEBOUNCE_CYC = 270_000
) (
   input  logic clk,
   input  logic rstn,
   input  logic key_i,
   output logic press_o
);

   localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          armed_q, armed_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Debounce counter, release-arming and press detection
   always_comb begin
      stable_d = stable_q;
      cnt_d    = {CW{1'b0}};
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = {CW{1'b0}};
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = {CW{1'b0}};
      end
      // a key held through reset must be seen released before it can fire
      armed_d = armed_q | ~sync2_q;
      press_d = stable_d & ~stable_q & armed_q;
   end

   // Synchronizer (resets to "pressed" so a held key never looks like a new press) and state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b0;
         cnt_q    <= {CW{1'b0}};
         armed_q  <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= key_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
         press_q  <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Six-LED sequencer: two debounced keys select mode and run/pause; a prescaled
// tick advances binary/scan/breathe/Gray patterns onto a registered LED bus.
module led_mode_sequencer
   import led_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 270_000,
   parameter int TICK_DIV     = 1_048_576
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             key_mode_i,
   input  logic             key_run_i,
   output logic [LED_W-1:0] led_o,
   output logic [1:0]       mode_o,
   output logic             running_o
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic             mode_press_s, run_press_s, tick_s;
   logic [TW-1:0]    tdiv_q, tdiv_d;
   mode_t            mode_q, mode_d;
   logic             running_q, running_d;
   logic [LED_W-1:0] cnt_q, cnt_d;
   logic [2:0]       pos_q, pos_d;
   logic             dir_q, dir_d;
   logic [5:0]       duty_q, duty_d;
   logic [5:0]       pwm_q, pwm_d;
   logic [LED_W-1:0] led_q, led_d;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode (
      .clk(clk), .rstn(rstn), .key_i(key_mode_i), .press_o(mode_press_s)
   );

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_run (
      .clk(clk), .rstn(rstn), .key_i(key_run_i), .press_o(run_press_s)
   );

   // Tick divider, mode/run control and pattern next-state
   always_comb begin
      tick_s    = running_q && (tdiv_q == TICK_LAST);
      tdiv_d    = tdiv_q;
      running_d = running_q ^ run_press_s;
      mode_d    = mode_press_s ? next_mode(mode_q) : mode_q;
      cnt_d     = cnt_q;
      pos_d     = pos_q;
      dir_d     = dir_q;
      duty_d    = duty_q;
      pwm_d     = pwm_q + 6'd1;

      if (running_q) begin
         tdiv_d = tick_s ? {TW{1'b0}} : tdiv_q + TW'(1);
      end else begin
         tdiv_d = tdiv_q;
      end

      if (tick_s && (mode_q == MODE_BINARY || mode_q == MODE_GRAY)) begin
         cnt_d = cnt_q + 6'd1;
      end else begin
         cnt_d = cnt_q;
      end

      // a mode change restarts the bounce even if a tick lands in the same cycle
      if (mode_press_s) begin
         pos_d  = 3'd0;
         dir_d  = 1'b0;
         duty_d = 6'd0;
      end else if (tick_s) begin
         case (mode_q)
            MODE_SCAN: begin
               if (dir_q) begin
                  pos_d = pos_q - 3'd1;
                  dir_d = (pos_q == 3'd1) ? 1'b0 : 1'b1;
               end else begin
                  pos_d = pos_q + 3'd1;
                  dir_d = (pos_q == 3'(SCAN_LAST - 1)) ? 1'b1 : 1'b0;
               end
            end
            MODE_BREATHE: begin
               if (dir_q) begin
                  duty_d = duty_q - 6'd1;
                  dir_d  = (duty_q == 6'd1) ? 1'b0 : 1'b1;
               end else begin
                  duty_d = duty_q + 6'd1;
                  dir_d  = (duty_q == 6'(DUTY_MAX - 1)) ? 1'b1 : 1'b0;
               end
            end
            default: begin
               pos_d  = pos_q;
               duty_d = duty_q;
            end
         endcase
      end else begin
         pos_d  = pos_q;
         duty_d = duty_q;
      end

      case (mode_q)
         MODE_BINARY:  led_d = cnt_q;
         MODE_SCAN:    led_d = 6'd1 << pos_q;
         MODE_BREATHE: led_d = {LED_W{pwm_q < duty_q}};
         MODE_GRAY:    led_d = bin_to_gray(cnt_q);
         default:      led_d = 6'd0;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tdiv_q    <= {TW{1'b0}};
         mode_q    <= MODE_BINARY;
         running_q <= 1'b1;
         cnt_q     <= 6'd0;
         pos_q     <= 3'd0;
         dir_q     <= 1'b0;
         duty_q    <= 6'd0;
         pwm_q     <= 6'd0;
         led_q     <= 6'd0;
      end else begin
         tdiv_q    <= tdiv_d;
         mode_q    <= mode_d;
         running_q <= running_d;
         cnt_q     <= cnt_d;
         pos_q     <= pos_d;
         dir_q     <= dir_d;
         duty_q    <= duty_d;
         pwm_q     <= pwm_d;
         led_q     <= led_d;
      end
   end

   assign led_o     = led_q;
   assign mode_o    = mode_q;
   assign running_o = running_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer: directed phases plus random key
// activity, compared every cycle against a behavioural model.
module tb_led_mode_sequencer;

   localparam int DEB  = 4;
   localparam int TDIV = 8;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       key_mode = 1'b0;
   logic       key_run = 1'b0;
   logic [5:0] led;
   logic [1:0] mode;
   logic       running;

   always #5 clk = ~clk;

   led_mode_sequencer #(.DEBOUNCE_CYC(DEB), .TICK_DIV(TDIV)) dut (
      .clk(clk), .rstn(rstn), .key_mode_i(key_mode), .key_run_i(key_run),
      .led_o(led), .mode_o(mode), .running_o(running)
   );

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model state: the scan/breathe position is derived from steps since last clear
   int m_mode, m_run, m_cnt, m_steps, m_pwm, m_tdiv, m_led;
   bit m_pend[2];
   bit m_hist[2][$];
   bit m_win[2][$];
   bit m_stab[2];
   bit m_armed[2];

   function automatic int tri_wave(input int k, input int top);
      int p;
      p = k % (2 * top);
      return (p <= top) ? p : 2 * top - p;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_run = 1; m_cnt = 0; m_steps = 0;
      m_pwm = 0; m_tdiv = 0; m_led = 0;
      for (int i = 0; i < 2; i++) begin
         m_pend[i] = 1'b0;
         m_stab[i] = 1'b0;
         m_armed[i] = 1'b0;
         m_hist[i].delete();
         m_hist[i].push_back(1'b1);
         m_hist[i].push_back(1'b1);
         m_win[i].delete();
         for (int j = 0; j < DEB; j++) m_win[i].push_back(1'b0);
      end
   endtask

   task automatic model_step();
      bit tick, s, all_diff, k;
      int pos, duty;
      tick = (m_run == 1) && (m_tdiv == TDIV - 1);
      pos  = tri_wave(m_steps, 5);
      duty = tri_wave(m_steps, 63);
      case (m_mode)
         0:       m_led = m_cnt;
         1:       m_led = 1 << pos;
         2:       m_led = (m_pwm < duty) ? 63 : 0;
         default: m_led = m_cnt ^ (m_cnt >> 1);
      endcase
      if (m_run == 1) m_tdiv = (m_tdiv + 1) % TDIV;
      if (tick && (m_mode == 0 || m_mode == 3)) m_cnt = (m_cnt + 1) % 64;
      if (m_pend[0]) m_steps = 0;
      else if (tick && (m_mode == 1 || m_mode == 2)) m_steps++;
      m_mode = (m_mode + int'(m_pend[0])) % 4;
      m_run  = m_run ^ int'(m_pend[1]);
      m_pwm  = (m_pwm + 1) % 64;
      for (int i = 0; i < 2; i++) begin
         k = (i == 0) ? key_mode : key_run;
         s = m_hist[i].pop_front();
         m_hist[i].push_back(k);
         m_win[i].push_back(s);
         void'(m_win[i].pop_front());
         all_diff = 1'b1;
         foreach (m_win[i][j]) if (m_win[i][j] == m_stab[i]) all_diff = 1'b0;
         m_pend[i] = 1'b0;
         if (all_diff) begin
            m_stab[i] = ~m_stab[i];
            if (m_stab[i] && m_armed[i]) m_pend[i] = 1'b1;
         end
         if (!s) m_armed[i] = 1'b1;
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      if (!rstn) model_reset();
      else model_step();
      check("led", led, m_led);
      check("mode", mode, m_mode);
      check("running", running, m_run);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) cyc();
   endtask

   task automatic press_run(input int len);
      key_run = 1'b1; wait_cyc(len); key_run = 1'b0; wait_cyc(12);
   endtask

   task automatic press_mode(input int len);
      key_mode = 1'b1; wait_cyc(len); key_mode = 1'b0; wait_cyc(12);
   endtask

   initial begin
      int ones;
      model_reset();
      wait_cyc(3);
      check("rst_led", led, 0);
      check("rst_mode", mode, 0);
      check("rst_running", running, 1);
      rstn = 1'b1;

      // free count through a full 64-step wrap
      wait_cyc(64 * TDIV + 6);
      check("wrap_led", led, m_cnt);

      // short glitch ignored, long press pauses, second press resumes
      press_run(3);
      check("glitch_run", running, 1);
      press_run(10);
      check("paused", running, 0);
      wait_cyc(200);
      press_run(10);
      check("resumed", running, 1);
      wait_cyc(40);

      // enter SCAN while paused so the first pattern is exactly 000001
      press_run(10);
      press_mode(8);
      check("scan_mode", mode, 1);
      check("scan_first", led, 6'h01);
      press_run(10);
      wait_cyc(12 * TDIV);

      // BREATHE: run ~10 ticks, pause, measure duty over one pwm period
      press_mode(8);
      check("breathe_mode", mode, 2);
      wait_cyc(10 * TDIV - 24);
      press_run(10);
      ones = 0;
      for (int i = 0; i < 64; i++) begin
         cyc();
         if (led == 6'h3f) ones++;
      end
      check("breathe_duty", ones, tri_wave(m_steps, 63));

      // GRAY then wrap back to BINARY, still paused
      press_mode(8);
      check("gray_mode", mode, 3);
      check("gray_led", led, m_cnt ^ (m_cnt >> 1));
      press_mode(8);
      check("wrap_mode", mode, 0);
      check("binary_led", led, m_cnt);
      press_run(10);

      // reset in the middle of SCAN with the mode key held across release
      press_mode(8);
      wait_cyc(30);
      key_mode = 1'b1;
      wait_cyc(3);
      rstn = 1'b0;
      #1;
      check("arst_led", led, 0);
      check("arst_mode", mode, 0);
      check("arst_running", running, 1);
      wait_cyc(3);
      rstn = 1'b1;
      wait_cyc(40);
      check("held_mode", mode, 0);
      key_mode = 1'b0;
      wait_cyc(20);
      press_mode(8);
      check("repress_mode", mode, 1);

      // random key activity, occasional reset
      repeat (150) begin
         int r, len;
         r   = $urandom_range(0, 3);
         len = $urandom_range(1, 10);
         key_mode = r[0];
         key_run  = r[1];
         wait_cyc(len);
         key_mode = 1'b0;
         key_run  = 1'b0;
         wait_cyc($urandom_range(1, 25));
         if ($urandom_range(0, 40) == 0) begin
            rstn = 1'b0;
            wait_cyc(2);
            rstn = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/led_mode_sequencer.md
# led_mode_sequencer

Board-level controller that sequences the six user LEDs on the Tang Nano 20K from the two push-buttons. It debounces both keys and generates a prescaled step tick. It also runs a four-mode display state machine (binary count, scan, breathe, Gray count) and gates the whole sequence with a run/pause toggle. It sits directly under the board top, between the raw key pins and the LED pins.

## Interface
- DEBOUNCE_CYC, 270_000: consecutive stable cycles required to accept a key level (10 ms at 27 MHz).
- TICK_DIV, 1_048_576: clk cycles per step tick (must be ≥ 2).
- clk  in  1  system clock, 27 MHz.
- rstn  in  1  asynchronous, active-low reset.
- key_mode  in  1  raw mode button, active-high pressed, asynchronous to clk.
- key_run  in  1  raw run/pause button, active-high pressed, asynchronous to clk.
- led  out  6  registered LED drive, 1 = lit.
- mode  out  2  current display mode (0 BINARY, 1 SCAN, 2 BREATHE, 3 GRAY).
- running  out  1  1 = sequence advancing, 0 = paused.

## Operation
- Each key: 2-FF synchronizer feeding a debouncer. The stable level changes only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles. Any agreeing cycle clears the counter. A rising edge of the stable level emits a one-cycle press pulse; releases emit nothing.
- run_press toggles running. mode_press advances mode 0→1→2→3→0. Both pulses in the same cycle are both applied.
- Tick counter counts 0..TICK_DIV-1 and wraps.
  - tick pulses on the wrap cycle only while running=1.
  - While paused, the counter holds its value and no tick is issued.
- State registers: cnt[5:0], pos[2:0], dir, duty[5:0], plus a free-running pwm[5:0] that increments every clk regardless of running.
- Per tick, by mode:
  - BINARY and GRAY: cnt+1, wrapping 63→0.
  - SCAN: pos steps toward 5 while dir=0 and toward 0 while dir=1. dir flips on reaching an end, giving 0,1,2,3,4,5,4,...,0,1.
  - BREATHE: duty steps the same bounce over 0..63 using dir.
- led by mode:
  - BINARY: cnt.
  - SCAN: one-hot 1<<pos.
  - BREATHE: all six bits = (pwm < duty).
  - GRAY: cnt ^ (cnt>>1).
- On mode_press:
  - pos, duty and dir clear to 0; cnt is preserved.
  - If a tick coincides with mode_press, the clear wins and the tick is discarded for SCAN/BREATHE state. cnt still increments.

## Timing
- Reset values: led=0, mode=0, running=1, cnt=0, pos=0, dir=0, duty=0, pwm=0, tick counter=0, debouncers stable=0.
- Key-to-event latency: 2 sync cycles + DEBOUNCE_CYC cycles. The press pulse is asserted in the cycle the stable level rises.
- mode and running update on the clk edge after the press pulse.
- Tick to led: state updates on the edge ending the tick cycle; led reflects it one edge later (registered output).
- Glitches shorter than DEBOUNCE_CYC produce no event.
- Holding a key produces exactly one event.
- Asynchronous reset mid-operation forces all reset values immediately. Keys held across reset release must be released and re-pressed to produce an event.

## Structure
- Package led_seq_pkg: mode enum (MODE_BINARY, MODE_SCAN, MODE_BREATHE, MODE_GRAY), LED_W=6, SCAN_LAST=5, DUTY_MAX=63.
- Sub-module key_debounce (sync + debounce + press pulse, parameter DEBOUNCE_CYC), instantiated twice.
- Tick divider, mode FSM, pattern state and output register live in led_mode_sequencer.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, TICK_DIV=8.
- Reset, no keys, 64 ticks: led steps 0,1,2,...,63, then 0; mode=0, running=1; each increment appears 1 cycle after the tick.
- Pulse key_run high for 3 cycles: no toggle. Hold 10 cycles: running=0 exactly once, and led frozen for 200 cycles. Second press: counting resumes from the frozen value.
- Press key_mode once: mode=1 and led=000001. Over 12 ticks led = 02,04,08,10,20,10,08,04,02,01,02,04 (hex).
- Second press, BREATHE: after 10 ticks duty=10; led is all-ones for exactly 10 of every 64 cycles.
- Third press, GRAY with cnt=5: led=000111. Fourth press: mode wraps to 0 and led=5.
- Assert rstn low mid-SCAN while key_mode is held: all outputs return to reset values, and releasing rstn with the key still held yields no mode change.
